// File: rtl/multdiv_scheduler.sv
// Sequences the shared multdiv unit: one issue at a time, holds the result until the
// regfile write port is free (W stage has priority), and generates targeted D/X stalls.
module multdiv_scheduler #(
   parameter int unsigned MULT_STATUS = 4,
   parameter int unsigned DIV_STATUS  = 5,
   parameter int unsigned MAX_CYCLES  = 40
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        issue_valid,
   input  logic        issue_isDiv,
   input  logic [4:0]  issue_rd,
   output logic        issue_ready,
   output logic        md_start_mult,
   output logic        md_start_div,
   input  logic        md_resultRDY,
   input  logic        md_exception,
   input  logic [31:0] md_result,
   input  logic        w_writeEnable,
   input  logic [4:0]  w_writeReg,
   input  logic [31:0] w_data,
   input  logic [4:0]  d_readRegA,
   input  logic [4:0]  d_readRegB,
   output logic        ctrl_writeEnable,
   output logic [4:0]  ctrl_writeReg,
   output logic [31:0] data_writeReg,
   output logic        stall,
   output logic        busy
);

   typedef enum logic [1:0] {StIdle, StRun, StWb} state_e;

   state_e      state_q, state_d;
   logic [4:0]  rd_q;
   logic        is_div_q;
   logic        squash_q;
   logic [5:0]  cnt_q;
   logic [31:0] hold_result_q;
   logic        hold_exc_q;
   logic        start_mult_q, start_div_q;

   logic        accept, first_run, rdy, timeout, waw_hit;
   logic [4:0]  tgt_reg;
   logic [31:0] tgt_data;
   logic        sched_slot, sched_we, dep_a, dep_b;

   assign accept    = (state_q == StIdle) && issue_valid;
   assign first_run = (state_q == StRun) && (cnt_q == 6'd0);
   assign rdy       = (state_q == StRun) && !first_run && md_resultRDY;
   assign timeout   = (state_q == StRun) && (cnt_q == 6'(MAX_CYCLES - 1));
   assign waw_hit   = w_writeEnable && (w_writeReg == rd_q) && (rd_q != 5'd0);

   // State register plus datapath holding registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= StIdle;
         rd_q          <= 5'd0;
         is_div_q      <= 1'b0;
         squash_q      <= 1'b0;
         cnt_q         <= 6'd0;
         hold_result_q <= 32'd0;
         hold_exc_q    <= 1'b0;
         start_mult_q  <= 1'b0;
         start_div_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_mult_q <= accept && !issue_isDiv;
         start_div_q  <= accept && issue_isDiv;
         if (accept) begin
            rd_q     <= issue_rd;
            is_div_q <= issue_isDiv;
            squash_q <= 1'b0;
            cnt_q    <= 6'd0;
         end
         if (state_q == StRun) begin
            cnt_q <= (cnt_q != 6'h3f) ? cnt_q + 6'd1 : cnt_q;
            // RDY beats a same-cycle timeout so a real exception flag is kept.
            if (rdy) begin
               hold_result_q <= md_result;
               hold_exc_q    <= md_exception;
            end else if (timeout) begin
               hold_exc_q <= 1'b1;
            end
         end
         // A later in-order W write to the same rd makes the pending result stale.
         if ((state_q != StIdle) && waw_hit) begin
            squash_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (issue_valid) state_d = StRun;
         StRun:   if (rdy || timeout) state_d = StWb;
         StWb:    if (!w_writeEnable) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy          = (state_q != StIdle);
      issue_ready   = (state_q == StIdle);
      md_start_mult = start_mult_q;
      md_start_div  = start_div_q;

      tgt_reg  = hold_exc_q ? 5'd30 : rd_q;
      tgt_data = hold_exc_q ? (is_div_q ? 32'(DIV_STATUS) : 32'(MULT_STATUS)) : hold_result_q;

      sched_slot = !reset && (state_q == StWb) && !w_writeEnable;
      sched_we   = sched_slot && (tgt_reg != 5'd0) && (hold_exc_q || !squash_q);

      ctrl_writeEnable = sched_slot ? sched_we : w_writeEnable;
      ctrl_writeReg    = sched_we ? tgt_reg : w_writeReg;
      data_writeReg    = sched_we ? tgt_data : w_data;

      dep_a = (d_readRegA != 5'd0) && ((d_readRegA == rd_q) || (d_readRegA == 5'd30));
      dep_b = (d_readRegB != 5'd0) && ((d_readRegB == rd_q) || (d_readRegB == 5'd30));
      stall = (issue_valid && !issue_ready) || (busy && (dep_a || dep_b));
   end

endmodule

// File: tb/tb_multdiv_scheduler.sv
// Scoreboard bench for multdiv_scheduler: expected scheduler writes are queued at issue
// time and a negedge monitor checks every regfile port write against them.
module tb_multdiv_scheduler;

   logic        clock = 1'b0;
   logic        reset;
   logic        issue_valid, issue_isDiv;
   logic [4:0]  issue_rd;
   logic        issue_ready, md_start_mult, md_start_div;
   logic        md_resultRDY, md_exception;
   logic [31:0] md_result;
   logic        w_writeEnable;
   logic [4:0]  w_writeReg;
   logic [31:0] w_data;
   logic [4:0]  d_readRegA, d_readRegB;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic        stall, busy;

   multdiv_scheduler #(
      .MULT_STATUS(4),
      .DIV_STATUS (5),
      .MAX_CYCLES (40)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .issue_valid     (issue_valid),
      .issue_isDiv     (issue_isDiv),
      .issue_rd        (issue_rd),
      .issue_ready     (issue_ready),
      .md_start_mult   (md_start_mult),
      .md_start_div    (md_start_div),
      .md_resultRDY    (md_resultRDY),
      .md_exception    (md_exception),
      .md_result       (md_result),
      .w_writeEnable   (w_writeEnable),
      .w_writeReg      (w_writeReg),
      .w_data          (w_data),
      .d_readRegA      (d_readRegA),
      .d_readRegB      (d_readRegB),
      .ctrl_writeEnable(ctrl_writeEnable),
      .ctrl_writeReg   (ctrl_writeReg),
      .data_writeReg   (data_writeReg),
      .stall           (stall),
      .busy            (busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
      int          c;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push(input logic [4:0] r, input logic [31:0] d, input int c);
      exp_t e;
      e.r = r;
      e.d = d;
      e.c = c;
      exp_q.push_back(e);
   endtask

   // Monitor: W requests must pass straight through; anything else must be a queued write.
   always @(negedge clock) begin
      exp_t e;
      if (w_writeEnable) begin
         chk("w_pass_we", ctrl_writeEnable, 1'b1);
         chk("w_pass_reg", ctrl_writeReg, w_writeReg);
         chk("w_pass_data", data_writeReg, w_data);
      end else if (ctrl_writeEnable) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write_reg", ctrl_writeReg, 5'd0);
            chk("unexpected_write_we", ctrl_writeEnable, 1'b0);
         end else begin
            e = exp_q.pop_front();
            chk("wr_reg", ctrl_writeReg, e.r);
            chk("wr_data", data_writeReg, e.d);
            chk("wr_cycle", cyc, e.c);
         end
      end
   end

   task automatic next();
      @(posedge clock);
      #1;
   endtask

   // Presents one issue, checks it is accepted, returns the start-pulse cycle number.
   task automatic issue(input logic isdiv, input logic [4:0] rd, output int acc);
      issue_valid = 1'b1;
      issue_isDiv = isdiv;
      issue_rd    = rd;
      @(negedge clock);
      chk("issue_ready", issue_ready, 1'b1);
      next();
      issue_valid = 1'b0;
      acc = cyc;
   endtask

   int acc;

   initial begin
      reset = 1'b1;
      issue_valid = 0; issue_isDiv = 0; issue_rd = 0;
      md_resultRDY = 0; md_exception = 0; md_result = 0;
      w_writeEnable = 1; w_writeReg = 5'd7; w_data = 32'h77;
      d_readRegA = 0; d_readRegB = 0;
      next();
      next();
      reset = 1'b0;
      w_writeEnable = 0;
      @(negedge clock);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", issue_ready, 1'b1);
      chk("rst_stall", stall, 1'b0);
      chk("rst_start_mult", md_start_mult, 1'b0);
      chk("rst_start_div", md_start_div, 1'b0);
      chk("rst_we", ctrl_writeEnable, 1'b0);
      next();

      // Mult 6x7 -> r5, L=10; D reads r5; RDY in IDLE and first RUN cycle is ignored.
      d_readRegA = 5'd5;
      md_resultRDY = 1; md_result = 32'h55;
      issue(1'b0, 5'd5, acc);
      push(5'd5, 32'd42, acc + 11);
      for (int i = 0; i <= 12; i++) begin
         md_resultRDY = (i == 0) || (i == 10);
         md_result    = (i == 10) ? 32'd42 : 32'd99;
         @(negedge clock);
         chk("t1_start_mult", md_start_mult, i == 0);
         chk("t1_start_div", md_start_div, 1'b0);
         chk("t1_stall", stall, i <= 11);
         chk("t1_busy", busy, i <= 11);
         next();
      end
      md_resultRDY = 0;
      d_readRegA = 0;

      // Div exception -> single $r30=5; D reads r6 (no hazard), briefly r30 and X issue.
      d_readRegA = 5'd6;
      issue(1'b1, 5'd8, acc);
      push(5'd30, 32'd5, acc + 4);
      for (int i = 0; i <= 5; i++) begin
         issue_valid  = (i == 1);
         d_readRegB   = (i == 2) ? 5'd30 : 5'd0;
         md_resultRDY = (i == 3);
         md_exception = (i == 3);
         md_result    = 32'h1234;
         @(negedge clock);
         if (i == 0) begin
            chk("t2_start_div", md_start_div, 1'b1);
            chk("t2_start_mult", md_start_mult, 1'b0);
         end
         chk("t2_stall", stall, (i == 1) || (i == 2));
         chk("t2_busy", busy, i <= 4);
         next();
      end
      md_resultRDY = 0; md_exception = 0; d_readRegA = 0; d_readRegB = 0;

      // W holds the port for 3 cycles; pending r9 written on the 4th.
      issue(1'b0, 5'd9, acc);
      push(5'd9, 32'h99, acc + 6);
      for (int i = 0; i <= 7; i++) begin
         md_resultRDY  = (i == 2);
         md_result     = 32'h99;
         w_writeEnable = (i >= 3) && (i <= 5);
         w_writeReg    = 5'd3;
         w_data        = 32'h300 + i;
         @(negedge clock);
         chk("t3_busy", busy, i <= 6);
         next();
      end
      md_resultRDY = 0; w_writeEnable = 0;

      // W writes r5 in the scheduler's write cycle: squashed, no scheduler write.
      issue(1'b0, 5'd5, acc);
      for (int i = 0; i <= 5; i++) begin
         md_resultRDY  = (i == 2);
         md_result     = 32'hAA;
         w_writeEnable = (i == 3);
         w_writeReg    = 5'd5;
         w_data        = 32'h55;
         @(negedge clock);
         chk("t4_busy", busy, i <= 4);
         next();
      end
      md_resultRDY = 0; w_writeEnable = 0;

      // Squash must not suppress the exception write.
      issue(1'b1, 5'd5, acc);
      push(5'd30, 32'd5, acc + 3);
      for (int i = 0; i <= 4; i++) begin
         w_writeEnable = (i == 1);
         w_writeReg    = 5'd5;
         w_data        = 32'h5A;
         md_resultRDY  = (i == 2);
         md_exception  = (i == 2);
         @(negedge clock);
         chk("t4b_busy", busy, i <= 3);
         next();
      end
      md_resultRDY = 0; md_exception = 0; w_writeEnable = 0;

      // rd = r0: no write, still returns to IDLE.
      issue(1'b0, 5'd0, acc);
      for (int i = 0; i <= 3; i++) begin
         md_resultRDY = (i == 1);
         md_result    = 32'hDEAD;
         @(negedge clock);
         chk("t4c_busy", busy, i <= 2);
         next();
      end
      md_resultRDY = 0;

      // Timeout: no RDY, WB after 40 RUN cycles, $r30 = MULT_STATUS.
      issue(1'b0, 5'd12, acc);
      push(5'd30, 32'd4, acc + 40);
      for (int i = 0; i <= 41; i++) begin
         @(negedge clock);
         chk("t5_busy", busy, i <= 40);
         next();
      end

      // RDY in the timeout cycle wins.
      issue(1'b1, 5'd12, acc);
      push(5'd12, 32'hBEEF, acc + 40);
      for (int i = 0; i <= 41; i++) begin
         md_resultRDY = (i == 39);
         md_result    = 32'hBEEF;
         @(negedge clock);
         chk("t5b_busy", busy, i <= 40);
         next();
      end
      md_resultRDY = 0;

      // Reset 3 cycles after accept; late RDY ignored; new issue accepted at once.
      issue(1'b0, 5'd7, acc);
      for (int i = 0; i <= 2; i++) begin
         reset = (i == 2);
         next();
      end
      reset = 0;
      md_resultRDY = 1; md_result = 32'h77;
      issue_valid = 1; issue_isDiv = 0; issue_rd = 5'd10;
      @(negedge clock);
      chk("t6_busy", busy, 1'b0);
      chk("t6_ready", issue_ready, 1'b1);
      chk("t6_no_start", md_start_mult, 1'b0);
      next();
      issue_valid = 0; md_resultRDY = 0;
      acc = cyc;
      push(5'd10, 32'h1010, acc + 3);
      for (int i = 0; i <= 4; i++) begin
         md_resultRDY = (i == 2);
         md_result    = 32'h1010;
         @(negedge clock);
         chk("t6_start_mult", md_start_mult, i == 0);
         chk("t6b_busy", busy, i <= 3);
         next();
      end
      md_resultRDY = 0;

      repeat (3) next();
      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
